mem_bus_arbiter: RTL and testbench

- Shares the single external memory bus between two requesters: port 0 is the instruction-fetch cache and port 1 is the data-side cache/LSU.
- Grants the bus for one whole transaction: request phase, then either write data beats or the read response burst.
- Routes request signals from the granted requester to the bus, and routes acks and responses back to that requester only.
- Sits between the fetch/memory-stage caches and the top-level bus interface. Only one transaction is outstanding at a time.

---
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external memory bus between instruction fetch (port 0) and data side (port 1)
//   clk, reset                      clock, asynchronous active-high reset
//   m0_* / m1_*                     requester ports: reqcyc/req/reqtag/reqack, respcyc/resp/resptag/respack
//   bus_*                           external bus: reqcyc/req/reqtag/reqack, respcyc/resp/resptag/respack
//   grant                           one-hot bus owner, 00 when idle
//   ARB_ROUND_ROBIN_EN              when defined, simultaneous requests alternate instead of port 1 always winning
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int RESP_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
    output logic                      m0_reqack,
    output logic                      m0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
    input  logic                      m0_respack,
    input  logic                      m1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    output logic                      m1_reqack,
    output logic                      m1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
    input  logic                      m1_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic [1:0]                grant
);
    localparam int CW = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] beat;
    logic [1:0]    winner;
    logic          in_req, in_resp, sel_reqcyc, sel_write, sel_respack, last_beat;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_win;

    // last_win is only consulted and updated when both ports contend
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_win <= 1'b0;
        else if (state == IDLE && m0_reqcyc && m1_reqcyc)
            last_win <= ~last_win;
    end

    always_comb begin
        winner = (m0_reqcyc && m1_reqcyc) ? (last_win ? 2'b01 : 2'b10) : (m1_reqcyc ? 2'b10 : 2'b01);
    end
`else
    always_comb begin
        winner = m1_reqcyc ? 2'b10 : 2'b01;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= 2'b00;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: if (m0_reqcyc || m1_reqcyc) begin
                    grant <= winner;
                    state <= REQ;
                end
                // a dropped reqcyc ends a write; it also frees the bus if a read is abandoned
                REQ: if (!sel_reqcyc) begin
                    grant <= 2'b00;
                    state <= IDLE;
                end else if (!sel_write && bus_reqack) begin
                    beat  <= '0;
                    state <= RESP;
                end
                RESP: if (bus_respcyc && sel_respack) begin
                    if (last_beat) begin
                        grant <= 2'b00;
                        beat  <= '0;
                        state <= IDLE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    beat  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_req      = state == REQ;
        in_resp     = state == RESP;
        sel_reqcyc  = grant[1] ? m1_reqcyc : m0_reqcyc;
        sel_write   = grant[1] ? m1_reqtag[BUS_TAG_WIDTH-1] : m0_reqtag[BUS_TAG_WIDTH-1];
        sel_respack = grant[1] ? m1_respack : m0_respack;
        last_beat   = beat == CW'(RESP_BEATS - 1);
        bus_reqcyc  = in_req & sel_reqcyc;
        bus_req     = grant[1] ? m1_req : grant[0] ? m0_req : '0;
        bus_reqtag  = grant[1] ? m1_reqtag : grant[0] ? m0_reqtag : '0;
        bus_respack = in_resp & sel_respack;
        m0_reqack   = in_req & grant[0] & bus_reqack;
        m1_reqack   = in_req & grant[1] & bus_reqack;
        m0_respcyc  = in_resp & grant[0] & bus_respcyc;
        m1_respcyc  = in_resp & grant[1] & bus_respcyc;
        m0_resp     = bus_resp;
        m1_resp     = bus_resp;
        m0_resptag  = bus_resptag;
        m1_resptag  = bus_resptag;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;

    logic          clk, reset;
    logic          m0_reqcyc, m0_reqack, m0_respcyc, m0_respack;
    logic [DW-1:0] m0_req, m0_resp;
    logic [TW-1:0] m0_reqtag, m0_resptag;
    logic          m1_reqcyc, m1_reqack, m1_respcyc, m1_respack;
    logic [DW-1:0] m1_req, m1_resp;
    logic [TW-1:0] m1_reqtag, m1_resptag;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [DW-1:0] bus_req, bus_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag;
    logic [1:0]    grant;
    int            n_cmp = 0;
    int            n_bad = 0;
`ifdef ARB_ROUND_ROBIN_EN
    bit            last_w = 1'b0;
`endif

    mem_bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .RESP_BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag), .m0_reqack(m0_reqack),
        .m0_respcyc(m0_respcyc), .m0_resp(m0_resp), .m0_resptag(m0_resptag), .m0_respack(m0_respack),
        .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag), .m1_reqack(m1_reqack),
        .m1_respcyc(m1_respcyc), .m1_resp(m1_resp), .m1_resptag(m1_resptag), .m1_respack(m1_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [1:0] oh(input int p);
        return p != 0 ? 2'b10 : 2'b01;
    endfunction

    function automatic logic ack_of(input int p);
        return p != 0 ? m1_reqack : m0_reqack;
    endfunction

    function automatic logic respcyc_of(input int p);
        return p != 0 ? m1_respcyc : m0_respcyc;
    endfunction

    function automatic logic [DW-1:0] resp_of(input int p);
        return p != 0 ? m1_resp : m0_resp;
    endfunction

    function automatic logic [TW-1:0] resptag_of(input int p);
        return p != 0 ? m1_resptag : m0_resptag;
    endfunction

    task automatic set_req(input int p, input logic c, input logic [DW-1:0] d, input logic [TW-1:0] t);
        if (p != 0) begin
            m1_reqcyc = c; m1_req = d; m1_reqtag = t;
        end else begin
            m0_reqcyc = c; m0_req = d; m0_reqtag = t;
        end
    endtask

    task automatic set_respack(input int p, input logic a);
        if (p != 0) m1_respack = a;
        else m0_respack = a;
    endtask

    // arbitration model: port 1 wins contention, or contention alternates with round robin
    task automatic pick(input bit r0, input bit r1, output int w);
`ifdef ARB_ROUND_ROBIN_EN
        if (r0 && r1) begin
            w = last_w ? 0 : 1;
            last_w = (w == 1);
        end else begin
            w = r1 ? 1 : 0;
        end
`else
        w = r1 ? 1 : 0;
`endif
    endtask

    // entered one cycle after the request was raised; ends at the idle cycle after completion
    task automatic run_read(input int p, input logic [TW-1:0] tag, input logic [DW-1:0] addr,
                            input logic [DW-1:0] base, input int mode);
        int n, acked, cyc;
        logic rc, ra;
        logic [DW-1:0] d;
        n = $urandom_range(0, 2);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            bus_reqack = 1'(i == n);
            #1;
            n_cmp++;
            if ({grant, bus_reqcyc, bus_req, bus_reqtag, ack_of(p), ack_of(1 - p), bus_respack} !==
                {oh(p), 1'b1, addr, tag, 1'(i == n), 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL rd_req p%0d: grant=%b cyc=%b req=%h tag=%h ack=%b/%b respack=%b, want grant=%b cyc=1 req=%h tag=%h ack=%b/0 respack=0",
                         p, grant, bus_reqcyc, bus_req, bus_reqtag, ack_of(p), ack_of(1 - p), bus_respack, oh(p), addr, tag, i == n);
            end
        end
        @(negedge clk);
        set_req(p, 1'b0, '0, '0);
        bus_reqack = 1'b0;
        acked = 0;
        cyc = 0;
        while (acked < NB && cyc < 500) begin
            if (mode == 0) begin
                rc = 1'b1; ra = 1'b1;
            end else if (mode == 2) begin
                rc = 1'b1; ra = 1'(cyc >= 3);
            end else begin
                rc = 1'($urandom_range(0, 3) != 0); ra = 1'($urandom_range(0, 3) != 0);
            end
            d = base + DW'(acked);
            bus_respcyc = rc;
            set_respack(p, ra);
            bus_resp = d;
            bus_resptag = tag;
            #1;
            n_cmp++;
            if ({grant, bus_reqcyc, respcyc_of(p), respcyc_of(1 - p), bus_respack, ack_of(1 - p), resp_of(p), resptag_of(p)} !==
                {oh(p), 1'b0, rc, 1'b0, ra, 1'b0, d, tag}) begin
                n_bad++;
                $display("FAIL rd_resp p%0d beat%0d: grant=%b cyc=%b respcyc=%b/%b respack=%b oack=%b resp=%h rtag=%h, want grant=%b cyc=0 respcyc=%b/0 respack=%b oack=0 resp=%h rtag=%h",
                         p, acked, grant, bus_reqcyc, respcyc_of(p), respcyc_of(1 - p), bus_respack, ack_of(1 - p), resp_of(p), resptag_of(p), oh(p), rc, ra, d, tag);
            end
            if (rc && ra) acked++;
            cyc++;
            @(negedge clk);
        end
        if (acked < NB) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_timeout p%0d: acked=%0d, want %0d", p, acked, NB);
        end
        bus_respcyc = 1'b0;
        set_respack(p, 1'b0);
        #1;
        n_cmp++;
        if ({grant, bus_reqcyc, bus_respack} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rd_done p%0d: grant=%b cyc=%b respack=%b, want 00 0 0", p, grant, bus_reqcyc, bus_respack);
        end
    endtask

    task automatic run_write(input int p, input logic [TW-1:0] tag, input int beats, input logic [DW-1:0] base);
        int n;
        logic [DW-1:0] d;
        for (int b = 0; b < beats; b++) begin
            n = $urandom_range(0, 2);
            d = base + DW'(b);
            for (int i = 0; i <= n; i++) begin
                @(negedge clk);
                set_req(p, 1'b1, d, tag);
                bus_reqack = 1'(i == n);
                bus_respcyc = 1'($urandom_range(0, 1));
                set_respack(p, 1'b1);
                #1;
                n_cmp++;
                if ({grant, bus_reqcyc, bus_req, bus_reqtag, ack_of(p), ack_of(1 - p), bus_respack, respcyc_of(p)} !==
                    {oh(p), 1'b1, d, tag, 1'(i == n), 1'b0, 1'b0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL wr_beat p%0d b%0d: grant=%b cyc=%b req=%h tag=%h ack=%b/%b respack=%b respcyc=%b, want grant=%b cyc=1 req=%h tag=%h ack=%b/0 respack=0 respcyc=0",
                             p, b, grant, bus_reqcyc, bus_req, bus_reqtag, ack_of(p), ack_of(1 - p), bus_respack, respcyc_of(p), oh(p), d, tag, i == n);
                end
            end
        end
        @(negedge clk);
        set_req(p, 1'b0, '0, '0);
        bus_reqack = 1'b0;
        bus_respcyc = 1'b1;
        #1;
        n_cmp++;
        if ({grant, bus_reqcyc, bus_respack} !== {oh(p), 2'b00}) begin
            n_bad++;
            $display("FAIL wr_drop p%0d: grant=%b cyc=%b respack=%b, want %b 0 0", p, grant, bus_reqcyc, bus_respack, oh(p));
        end
        @(negedge clk);
        bus_respcyc = 1'b0;
        set_respack(p, 1'b0);
        #1;
        n_cmp++;
        if ({grant, bus_reqcyc, bus_respack} !== 4'b0000) begin
            n_bad++;
            $display("FAIL wr_done p%0d: grant=%b cyc=%b respack=%b, want 00 0 0", p, grant, bus_reqcyc, bus_respack);
        end
    endtask

    task automatic check_arb_cycle(input string name);
        #1;
        n_cmp++;
        if ({grant, bus_reqcyc} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s_arb: grant=%b cyc=%b, want 00 0", name, grant, bus_reqcyc);
        end
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({grant, bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_init: grant=%b cyc=%b respack=%b acks=%b%b respcyc=%b%b, want all 0",
                     grant, bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc);
        end
        m0_reqcyc = 1'b1; m1_reqcyc = 1'b1; bus_reqack = 1'b1; bus_respcyc = 1'b1; m0_respack = 1'b1; m1_respack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({grant, bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc} !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_hold: grant=%b cyc=%b respack=%b acks=%b%b respcyc=%b%b, want all 0",
                         grant, bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc);
            end
        end
        @(negedge clk);
        m0_reqcyc = 1'b0; m1_reqcyc = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0; m0_respack = 1'b0; m1_respack = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_read_port0;
        int w;
        @(negedge clk);
        set_req(0, 1'b1, 64'h1000, 13'h0001);
        check_arb_cycle("read0");
        pick(1'b1, 1'b0, w);
        run_read(w, 13'h0001, 64'h1000, 64'hA0, 0);
    endtask

    task automatic test_contention;
        int w;
        logic [DW-1:0] a0, a1;
        logic [TW-1:0] t0, t1;
        a0 = {$urandom, $urandom};
        a1 = {$urandom, $urandom};
        t0 = {1'b0, 12'($urandom)};
        t1 = {1'b0, 12'($urandom)};
        @(negedge clk);
        set_req(0, 1'b1, a0, t0);
        set_req(1, 1'b1, a1, t1);
        check_arb_cycle("contend");
        pick(1'b1, 1'b1, w);
        run_read(w, w != 0 ? t1 : t0, w != 0 ? a1 : a0, 64'hB0, 1);
        run_read(1 - w, w != 0 ? t0 : t1, w != 0 ? a0 : a1, 64'hC0, 1);
    endtask

    task automatic test_write_port1;
        @(negedge clk);
        set_req(1, 1'b1, 64'hD0, 13'h1002);
        check_arb_cycle("write1");
        run_write(1, 13'h1002, 3, 64'hD0);
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk);
        set_req(0, 1'b1, 64'h2000, 13'h0003);
        check_arb_cycle("rstmid");
        @(negedge clk);
        bus_reqack = 1'b1;
        @(negedge clk);
        set_req(0, 1'b0, '0, '0);
        bus_reqack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_respcyc = 1'b1; m0_respack = 1'b1; bus_resp = 64'hE0 + 64'(i);
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({grant, m0_respcyc} !== 3'b011) begin
            n_bad++;
            $display("FAIL rstmid_pre: grant=%b respcyc=%b, want 01 1", grant, m0_respcyc);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({grant, bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc} !== 8'h00) begin
            n_bad++;
            $display("FAIL rstmid_async: grant=%b cyc=%b respack=%b acks=%b%b respcyc=%b%b, want all 0",
                     grant, bus_reqcyc, bus_respack, m0_reqack, m1_reqack, m0_respcyc, m1_respcyc);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_respcyc = 1'b0;
        m0_respack = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_w = 1'b0;
`endif
        @(negedge clk);
        set_req(0, 1'b1, 64'h3000, 13'h0004);
        check_arb_cycle("rstmid_new");
        run_read(0, 13'h0004, 64'h3000, 64'hF0, 0);
    endtask

    task automatic test_stray;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_respcyc = 1'b1; m0_respack = 1'b1; m1_respack = 1'b1; bus_resp = {$urandom, $urandom};
            #1;
            n_cmp++;
            if ({grant, bus_respack, m0_respcyc, m1_respcyc, bus_reqcyc} !== 6'b000000) begin
                n_bad++;
                $display("FAIL stray: grant=%b respack=%b respcyc=%b%b cyc=%b, want all 0",
                         grant, bus_respack, m0_respcyc, m1_respcyc, bus_reqcyc);
            end
        end
        @(negedge clk);
        bus_respcyc = 1'b0; m0_respack = 1'b0; m1_respack = 1'b0;
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        set_req(0, 1'b1, 64'h4000, 13'h0005);
        check_arb_cycle("bp");
        run_read(0, 13'h0005, 64'h4000, 64'h100, 2);
    endtask

    task automatic run_txn(input int p, input bit wr, input logic [TW-1:0] tg, input logic [DW-1:0] ad);
        if (wr) run_write(p, tg, $urandom_range(1, 4), ad);
        else run_read(p, tg, ad, ad ^ 64'h5555, 1);
    endtask

    task automatic test_random;
        int w;
        bit r0, r1;
        bit wr [2];
        logic [TW-1:0] tg [2];
        logic [DW-1:0] ad [2];
        for (int k = 0; k < 10; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            for (int q = 0; q < 2; q++) begin
                wr[q] = 1'($urandom_range(0, 1));
                tg[q] = {wr[q], 12'($urandom)};
                ad[q] = {$urandom, $urandom};
            end
            @(negedge clk);
            if (r0) set_req(0, 1'b1, ad[0], tg[0]);
            if (r1) set_req(1, 1'b1, ad[1], tg[1]);
            check_arb_cycle("rand");
            pick(r0, r1, w);
            run_txn(w, wr[w], tg[w], ad[w]);
            if (r0 && r1) run_txn(1 - w, wr[1 - w], tg[1 - w], ad[1 - w]);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_reqcyc = 1'b0; m0_req = '0; m0_reqtag = '0; m0_respack = 1'b0;
        m1_reqcyc = 1'b0; m1_req = '0; m1_reqtag = '0; m1_respack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        test_reset;
        test_read_port0;
        test_contention;
        test_contention;
        test_write_port1;
        test_reset_mid_burst;
        test_stray;
        test_backpressure;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
